// File: rtl/mc_clks_alot.sv
// Multi-channel clock recovery: locks onto pre-synchronised external clocks,
// regenerates an expected clock per channel and offers a glitch-free pausable copy.
module mc_clks_alot #(
    parameter int CHANNELS   = 2,
    parameter int CNT_W      = 8,
    parameter int LOCK_EDGES = 4,
    parameter int TOL        = 1
) (
    input  logic                      clk_i,
    input  logic                      sync_rst_n_i,
    input  logic [CHANNELS-1:0]       en_i,
    input  logic [CHANNELS-1:0]       io_clk_i,
    output logic [CHANNELS-1:0]       lock_o,
    output logic [CHANNELS-1:0]       lock_err_o,
    output logic [CHANNELS*CNT_W-1:0] half_period_o,
    output logic [CHANNELS-1:0]       exp_clk_o,
    output logic [CHANNELS-1:0]       pre_clk_o,
    input  logic [CHANNELS-1:0]       pause_en_i,
    input  logic [CHANNELS-1:0]       pause_polarity_i,
    output logic [CHANNELS-1:0]       paused_o,
    output logic [CHANNELS-1:0]       p_exp_clk_o,
    output logic [CHANNELS-1:0]       p_pre_clk_o,
    output logic [CHANNELS-1:0]       pause_start_violation_o,
    output logic [CHANNELS-1:0]       pause_stop_violation_o
);
    localparam int                MW         = $clog2(LOCK_EDGES) + 1;
    localparam logic [CNT_W-1:0]  ONE        = CNT_W'(1);
    localparam logic [CNT_W:0]    TOL_W      = (CNT_W+1)'(TOL);
    localparam logic [CNT_W:0]    MIN_MEAS   = (CNT_W+1)'(2);
    localparam logic [MW-1:0]     LAST_MATCH = MW'(LOCK_EDGES - 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    typedef struct packed {
        state_t           state;
        logic             prev;
        logic             seen;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] refv;
        logic [MW-1:0]    match;
        logic [CNT_W-1:0] half;
        logic [CNT_W-1:0] phase;
        logic             exp_c;
        logic             pre_c;
        logic             lock;
        logic             lock_err;
        logic             paused;
        logic             pol;
        logic             p_exp;
        logic             p_pre;
        logic             start_v;
        logic             stop_v;
    } ch_t;

    function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W:0] a, input logic [CNT_W:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W:0] v);
        return v[CNT_W] ? '1 : v[CNT_W-1:0];
    endfunction

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        ch_t            cur;
        ch_t            nxt;
        logic           edg;
        logic           in_tol_ref;
        logic           in_tol_half;
        logic           lost;
        logic [CNT_W:0] meas;

        assign edg         = io_clk_i[i] ^ cur.prev;
        assign meas        = {1'b0, cur.cnt} + (CNT_W+1)'(1);
        assign in_tol_ref  = (abs_diff(meas, {1'b0, cur.refv}) <= TOL_W) && (meas >= MIN_MEAS);
        assign in_tol_half = (abs_diff(meas, {1'b0, cur.half}) <= TOL_W) && (meas >= MIN_MEAS);
        // A silent input for two half-periods is treated like a bad edge.
        assign lost        = (edg && !in_tol_half) || ({1'b0, cur.cnt} >= {cur.half, 1'b0});

        always_comb begin
            // NOTE: start from the held value so every field is assigned on every path and no latch is inferred.
            nxt          = cur;
            nxt.prev     = io_clk_i[i];
            nxt.lock_err = 1'b0;
            nxt.start_v  = 1'b0;
            nxt.stop_v   = 1'b0;
            if (edg)                nxt.cnt = '0;
            else if (cur.cnt != '1) nxt.cnt = cur.cnt + ONE;

            case (cur.state)
                ACQUIRE: begin
                    nxt.start_v = pause_en_i[i];
                    if (edg) begin
                        if (!cur.seen) begin
                            nxt.seen = 1'b1;
                        end else if (in_tol_ref) begin
                            if (cur.match == LAST_MATCH) begin
                                nxt.state = LOCKED;
                                nxt.lock  = 1'b1;
                                nxt.half  = cur.refv;
                                nxt.match = '0;
                                nxt.phase = '0;
                                nxt.exp_c = io_clk_i[i];
                            end else begin
                                nxt.match = cur.match + MW'(1);
                            end
                        end else begin
                            nxt.refv  = sat(meas);
                            nxt.match = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (lost) begin
                        nxt.state    = ACQUIRE;
                        nxt.lock     = 1'b0;
                        nxt.lock_err = 1'b1;
                        nxt.refv     = sat(meas);
                        nxt.match    = '0;
                        nxt.half     = '0;
                        nxt.phase    = '0;
                        nxt.stop_v   = cur.paused;
                    end else begin
                        if (edg) begin
                            nxt.phase = '0;
                            nxt.exp_c = io_clk_i[i];
                        end else if (cur.phase == cur.half - ONE) begin
                            nxt.phase = '0;
                            nxt.exp_c = ~cur.exp_c;
                        end else begin
                            nxt.phase = cur.phase + ONE;
                        end
                        // Engage/release only while the free-running clock sits at the held level.
                        if (cur.paused) begin
                            nxt.stop_v = pause_polarity_i[i] != cur.pol;
                            if (!pause_en_i[i] && cur.exp_c == cur.pol) nxt.paused = 1'b0;
                        end else if (pause_en_i[i] && cur.exp_c == pause_polarity_i[i]) begin
                            nxt.paused = 1'b1;
                            nxt.pol    = pause_polarity_i[i];
                        end
                    end
                end
                default: ;
            endcase

            if (nxt.state == LOCKED) begin
                nxt.pre_c = (nxt.phase == nxt.half - ONE) ? ~nxt.exp_c : nxt.exp_c;
                nxt.p_exp = nxt.paused ? nxt.pol : nxt.exp_c;
                nxt.p_pre = nxt.paused ? nxt.pol : nxt.pre_c;
            end else begin
                nxt.exp_c  = 1'b0;
                nxt.pre_c  = 1'b0;
                nxt.paused = 1'b0;
                nxt.p_exp  = 1'b0;
                nxt.p_pre  = 1'b0;
            end

            if (!en_i[i] || cur.state == IDLE) begin
                nxt       = '0;
                nxt.prev  = io_clk_i[i];
                nxt.state = en_i[i] ? ACQUIRE : IDLE;
            end
        end

        always_ff @(posedge clk_i) begin
            // NOTE: reset is synchronous and non-blocking, so the whole channel record updates together at the edge.
            if (!sync_rst_n_i) cur <= '0;
            else               cur <= nxt;
        end

        assign lock_o[i]                        = cur.lock;
        assign lock_err_o[i]                    = cur.lock_err;
        assign half_period_o[i*CNT_W +: CNT_W]  = cur.half;
        assign exp_clk_o[i]                     = cur.exp_c;
        assign pre_clk_o[i]                     = cur.pre_c;
        assign paused_o[i]                      = cur.paused;
        assign p_exp_clk_o[i]                   = cur.p_exp;
        assign p_pre_clk_o[i]                   = cur.p_pre;
        assign pause_start_violation_o[i]       = cur.start_v;
        assign pause_stop_violation_o[i]        = cur.stop_v;
    end
endmodule
